// File: rtl/restart_aware_cmd_arbiter.sv
// Credit-gated PSL command arbiter: strict-priority restart path over round-robin
// compute-unit requesters, with tagging, credit accounting and enable-driven re-init.
package restart_aware_cmd_arbiter_pkg;
  localparam int TAG_W = 8;

  typedef struct packed {
    logic [7:0]       opcode;
    logic [TAG_W-1:0] tag;
    logic [31:0]      addr;
  } psl_cmd_t;

  typedef struct packed {
    logic     valid;
    psl_cmd_t cmd;
  } CommandBufferLine;

  typedef enum logic [1:0] {ARB_RESET, ARB_INIT, ARB_RUN, ARB_HOLD} arb_state_e;
endpackage

module restart_aware_cmd_arbiter
  import restart_aware_cmd_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int CREDIT_W = 8
) (
  input  logic                clock,
  input  logic                rstn,
  input  logic                enabled_in,
  input  logic [NUM_REQ-1:0]  req_valid,
  input  CommandBufferLine    req_cmd [NUM_REQ],
  output logic [NUM_REQ-1:0]  req_grant,
  input  CommandBufferLine    restart_cmd_in,
  input  logic                restart_pending_in,
  output logic                restart_grant,
  input  logic [CREDIT_W-1:0] credits_total,
  input  logic                credit_return,
  output CommandBufferLine    command_out,
  output logic [CREDIT_W-1:0] command_tag_out,
  output logic [CREDIT_W-1:0] credits_out,
  output logic                credit_error
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_REQ - 1);

  arb_state_e          state_q, state_d;
  logic                enabled_q;
  logic [CREDIT_W-1:0] credits_q, tag_q;
  logic [PTR_W-1:0]    rr_ptr_q, grant_idx, scan_idx;
  logic                req_hit, can_grant, any_grant;
  CommandBufferLine    req_line;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ARB_RESET;
      enabled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      enabled_q <= enabled_in;
    end
  end

  // Dropping enable forces re-init at once; otherwise advance on the registered enable.
  always_comb begin
    state_d = state_q;
    if (!enabled_in) begin
      state_d = ARB_RESET;
    end else if (enabled_q) begin
      case (state_q)
        ARB_RESET: state_d = ARB_INIT;
        ARB_INIT:  state_d = ARB_RUN;
        ARB_RUN:   if (restart_pending_in) state_d = ARB_HOLD;
        ARB_HOLD:  if (!restart_pending_in && !restart_cmd_in.valid) state_d = ARB_RUN;
        default:   state_d = ARB_RESET;
      endcase
    end
  end

  // NOTE: every signal written here gets a default first, so no path infers a latch.
  always_comb begin
    req_grant     = '0;
    restart_grant = 1'b0;
    req_hit       = 1'b0;
    grant_idx     = rr_ptr_q;
    scan_idx      = rr_ptr_q;
    can_grant     = enabled_in && (state_q == ARB_RUN || state_q == ARB_HOLD)
                    && (credits_q != '0);
    if (can_grant) begin
      if (restart_cmd_in.valid) begin
        restart_grant = 1'b1;
      end else if (state_q == ARB_RUN) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          scan_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
          if (!req_hit && req_valid[scan_idx]) begin
            req_hit   = 1'b1;
            grant_idx = scan_idx;
          end
        end
        if (req_hit) req_grant[grant_idx] = 1'b1;
      end
    end
    any_grant = restart_grant | req_hit;
  end

  // Requester commands carry the local tag in place of whatever tag they arrived with.
  always_comb begin
    req_line         = req_cmd[grant_idx];
    req_line.valid   = 1'b1;
    req_line.cmd.tag = TAG_W'(tag_q);
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      credits_q       <= '0;
      tag_q           <= '0;
      rr_ptr_q        <= PTR_RST;
      credit_error    <= 1'b0;
      command_out     <= '0;
      command_tag_out <= '0;
    end else begin
      case (state_q)
        ARB_RESET: begin
          credits_q    <= '0;
          credit_error <= 1'b0;
        end
        ARB_INIT: credits_q <= credits_total;
        default: begin
          if (any_grant && !credit_return) begin
            credits_q <= credits_q - 1'b1;
          end else if (!any_grant && credit_return) begin
            if (credits_q == credits_total) credit_error <= 1'b1;
            else                            credits_q    <= credits_q + 1'b1;
          end
        end
      endcase

      if (!enabled_in) begin
        command_out <= '0;
      end else if (restart_grant) begin
        command_out     <= restart_cmd_in;
        command_tag_out <= CREDIT_W'(restart_cmd_in.cmd.tag);
      end else if (req_hit) begin
        command_out     <= req_line;
        command_tag_out <= tag_q;
        tag_q           <= tag_q + 1'b1;
        rr_ptr_q        <= grant_idx;
      end else begin
        command_out <= '0;
      end
    end
  end

  assign credits_out = credits_q;

endmodule

// File: tb/tb_restart_aware_cmd_arbiter.sv
// Directed bench for restart_aware_cmd_arbiter: inputs change 1ns after the rising edge,
// combinational grants are checked 1ns later, registered outputs right after each edge.
`timescale 1ns/1ps
module tb_restart_aware_cmd_arbiter;
  import restart_aware_cmd_arbiter_pkg::*;

  localparam int NUM_REQ  = 4;
  localparam int CREDIT_W = 8;

  logic                clock = 1'b0;
  logic                rstn;
  logic                enabled_in;
  logic [NUM_REQ-1:0]  req_valid;
  CommandBufferLine    req_cmd [NUM_REQ];
  logic [NUM_REQ-1:0]  req_grant;
  CommandBufferLine    restart_cmd_in;
  logic                restart_pending_in;
  logic                restart_grant;
  logic [CREDIT_W-1:0] credits_total;
  logic                credit_return;
  CommandBufferLine    command_out;
  logic [CREDIT_W-1:0] command_tag_out;
  logic [CREDIT_W-1:0] credits_out;
  logic                credit_error;

  int errors = 0;
  int checks = 0;

  restart_aware_cmd_arbiter #(.NUM_REQ(NUM_REQ), .CREDIT_W(CREDIT_W)) dut (
    .clock              (clock),
    .rstn               (rstn),
    .enabled_in         (enabled_in),
    .req_valid          (req_valid),
    .req_cmd            (req_cmd),
    .req_grant          (req_grant),
    .restart_cmd_in     (restart_cmd_in),
    .restart_pending_in (restart_pending_in),
    .restart_grant      (restart_grant),
    .credits_total      (credits_total),
    .credit_return      (credit_return),
    .command_out        (command_out),
    .command_tag_out    (command_tag_out),
    .credits_out        (credits_out),
    .credit_error       (credit_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic CommandBufferLine exp_req(input int i, input logic [7:0] tag);
    CommandBufferLine l;
    l.valid      = 1'b1;
    l.cmd.opcode = 8'h10 + 8'(i);
    l.cmd.tag    = tag;
    l.cmd.addr   = 32'hA000_0000 + 32'(i);
    return l;
  endfunction

  function automatic CommandBufferLine mk_restart(input logic [7:0] tag);
    CommandBufferLine l;
    l.valid      = 1'b1;
    l.cmd.opcode = 8'hF0;
    l.cmd.tag    = tag;
    l.cmd.addr   = 32'hDEAD_0000 + 32'(tag);
    return l;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] exp_vec;
    logic [7:0] exp_tag;
    int         first_cycle;
    logic [3:0] first_vec;

    for (int i = 0; i < NUM_REQ; i++) req_cmd[i] = exp_req(i, 8'hEE);
    restart_cmd_in     = '0;
    req_valid          = '0;
    credits_total      = 8'd4;
    credit_return      = 1'b0;
    restart_pending_in = 1'b0;
    enabled_in         = 1'b1;
    rstn               = 1'b0;

    // Reset state
    #3;
    check("rst_req_grant", req_grant, 0);
    check("rst_restart_grant", restart_grant, 0);
    check("rst_command_out", command_out, 0);
    check("rst_tag_out", command_tag_out, 0);
    check("rst_credits", credits_out, 0);
    check("rst_credit_error", credit_error, 0);

    // Bring-up with all requesters pending: first grant three edges after release
    @(posedge clock); #1;
    rstn      = 1'b1;
    req_valid = 4'hF;
    settle(); check("init_c0_grant", req_grant, 0);
    cyc(); cyc();
    settle(); check("init_c2_grant", req_grant, 0);
    cyc();
    settle();
    check("run_first_grant", req_grant, 4'b0001);
    check("run_credits_loaded", credits_out, 4);

    // Round-robin burst 0,1,2,3 drains the four credits
    for (int i = 0; i < 4; i++) begin
      cyc();
      check($sformatf("burst_cmd%0d", i), command_out, exp_req(i, 8'(i)));
      check($sformatf("burst_tag%0d", i), command_tag_out, i);
      check($sformatf("burst_credits%0d", i), credits_out, 3 - i);
      settle();
      exp_vec = (i < 3) ? (4'b0001 << (i + 1)) : 4'b0000;
      check($sformatf("burst_next_grant%0d", i), req_grant, exp_vec);
    end
    cyc();
    check("drained_cmd_valid", command_out.valid, 0);
    settle(); check("drained_grant", req_grant, 0);

    // Return at zero credits does not unlock a grant in the same cycle
    credit_return = 1'b1;
    settle(); check("ret_at_zero_no_grant", req_grant, 0);
    cyc();
    credit_return = 1'b0;
    check("ret_credit", credits_out, 1);
    settle(); check("grant_after_ret", req_grant, 4'b0001);
    cyc();
    req_valid = '0;
    check("grant_after_ret_tag", command_tag_out, 4);
    check("grant_after_ret_credits", credits_out, 0);

    // Refill, then overflow the allotment
    credit_return = 1'b1;
    repeat (4) cyc();
    check("refill_credits", credits_out, 4);
    check("refill_no_err", credit_error, 0);
    cyc();
    check("overflow_credits_hold", credits_out, 4);
    check("overflow_err", credit_error, 1);

    // Grant and return in the same cycle
    req_valid = 4'b0010;
    settle(); check("both_grant", req_grant, 4'b0010);
    cyc();
    req_valid     = '0;
    credit_return = 1'b0;
    check("both_credits", credits_out, 4);
    check("both_tag", command_tag_out, 5);
    check("err_sticky", credit_error, 1);

    // Restart beats a concurrent requester and leaves the tag counter alone
    restart_cmd_in = mk_restart(8'h5A);
    req_valid      = 4'b0100;
    settle();
    check("restart_prio_grant", restart_grant, 1);
    check("restart_prio_req_grant", req_grant, 0);
    cyc();
    restart_cmd_in = '0;
    check("restart_cmd", command_out, mk_restart(8'h5A));
    check("restart_tag", command_tag_out, 8'h5A);
    check("restart_credits", credits_out, 3);
    settle(); check("post_restart_grant", req_grant, 4'b0100);
    cyc();
    req_valid = '0;
    check("tag_unchanged_by_restart", command_tag_out, 6);
    check("post_restart_credits", credits_out, 2);
    credit_return = 1'b1;
    repeat (2) cyc();
    credit_return = 1'b0;
    check("refill2_credits", credits_out, 4);

    // Hold: requesters locked out, restarts still served, resume at rr pointer
    restart_pending_in = 1'b1;
    cyc();
    req_valid = 4'hF;
    settle(); check("hold_grant0", req_grant, 0);
    cyc();
    check("hold_no_cmd", command_out.valid, 0);
    settle(); check("hold_grant1", req_grant, 0);
    restart_cmd_in = mk_restart(8'h33);
    settle();
    check("hold_restart_grant", restart_grant, 1);
    check("hold_restart_req_grant", req_grant, 0);
    cyc();
    restart_cmd_in     = '0;
    restart_pending_in = 1'b0;
    check("hold_restart_cmd", command_out, mk_restart(8'h33));
    settle(); check("hold_exit_grant", req_grant, 0);
    cyc();
    settle(); check("resume_grant", req_grant, 4'b1000);
    cyc();
    req_valid = '0;
    check("resume_tag", command_tag_out, 7);
    check("resume_credits", credits_out, 2);
    credit_return = 1'b1;
    repeat (2) cyc();

    // 256 requester grants with a return each cycle: tag wraps 255 -> 0
    req_valid = 4'b0001;
    for (int k = 0; k < 256; k++) begin
      cyc();
      exp_tag = 8'(8 + k);
      if (exp_tag == 8'hFF || exp_tag == 8'h00) begin
        check($sformatf("wrap_tag_k%0d", k), command_tag_out, exp_tag);
        check($sformatf("wrap_cmd_tag_k%0d", k), command_out.cmd.tag, exp_tag);
      end
    end
    req_valid     = '0;
    credit_return = 1'b0;
    check("wrap_credits", credits_out, 4);

    // Reset while a command is in flight
    req_valid = 4'b0001;
    cyc();
    check("inflight_valid", command_out.valid, 1);
    rstn = 1'b0;
    #1;
    check("midrst_cmd", command_out, 0);
    check("midrst_tag", command_tag_out, 0);
    check("midrst_credits", credits_out, 0);
    check("midrst_err", credit_error, 0);
    check("midrst_req_grant", req_grant, 0);
    check("midrst_restart_grant", restart_grant, 0);
    req_valid = 4'hF;
    @(posedge clock); #1;
    rstn        = 1'b1;
    first_cycle = -1;
    first_vec   = '0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) cyc();
      settle();
      if (first_cycle < 0 && req_grant != 0) begin
        first_cycle = c;
        first_vec   = req_grant;
      end
    end
    check("post_rst_first_grant_cycle", first_cycle, 3);
    check("post_rst_first_grant_vec", first_vec, 4'b0001);

    // Disable: grants drop now, command_out clears, credits flushed by re-init
    enabled_in = 1'b0;
    settle(); check("dis_grant", req_grant, 0);
    cyc();
    check("dis_cmd", command_out, 0);
    cyc();
    check("dis_credits", credits_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
